add8u_share_arb: RTL and testbench
==================================

# add8u_share_arb

Round-robin arbiter and sequencer that shares one 8-bit unsigned adder core among `NREQ` requesters. Each requester presents an operand pair on a valid/ready port. The block grants one requester per cycle, registers the 9-bit sum with the winner's ID, and returns it on a single valid/ready response port. It sits between the client datapaths and the shared `add8u` instance, so an approximate adder can be time-multiplexed in FPGA builds.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: requester ID width; derived, not overridden.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in `NREQ`: per-requester operand valid.
- `req_ready` out `NREQ`: per-requester accept; one-hot or zero.
- `req_a` in `NREQ*8`: operand A; requester i uses bits `[8i+7:8i]`.
- `req_b` in `NREQ*8`: operand B; same packing as `req_a`.
- `rsp_valid` out 1: response holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_sum` out 9: sum of the granted pair.
- `rsp_id` out `IDW`: index of the granted requester.
- `op_count` out 16: count of completed response handshakes.

## Operation
- Output-register state is either EMPTY (`rsp_valid`=0) or FULL (`rsp_valid`=1).
- `can_issue` = `!rsp_valid || rsp_ready`.
- Grant selection:
  - When `can_issue` is set, grant the first `req_valid` bit, searching upward from `rr_ptr` with wrap at `NREQ-1` to 0.
  - `req_ready` = that one-hot grant. Otherwise `req_ready` = 0.
  - `req_ready` depends combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- On a grant to requester i:
  - Register `rsp_sum` = adder(`req_a[i]`, `req_b[i]`) and `rsp_id` = i.
  - Set `rsp_valid` = 1.
  - Set `rr_ptr` = (i+1) mod `NREQ`.
- If FULL and `rsp_ready`=1 with no grant, clear `rsp_valid`. `rsp_sum` and `rsp_id` hold their last values.
- If FULL and `rsp_ready`=0:
  - `rsp_sum`, `rsp_id` and `rsp_valid` hold.
  - `req_ready` = 0.
  - `rr_ptr` holds.
- Each `rsp_valid && rsp_ready` increments `op_count`. It wraps from 0xFFFF to 0x0000.
- A drain and a new grant in the same cycle keep the block FULL with the new data, and `op_count` increments.
- Sum width:
  - Exact mode: `rsp_sum` = zero-extended `a` + `b`, full 9 bits, never truncated.
  - Approximate mode is defined under Configuration.
- Reset (`rst_n`=0 at a clock edge) forces:
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `op_count`=0, `rr_ptr`=0.
  - `req_ready`=0 while `rst_n` is low.
- Reset mid-operation discards any held response with no handshake. An in-flight grant in the reset cycle is not registered.

## Timing
- Latency: a request accepted at edge t produces `rsp_valid`=1 after edge t, one cycle.
- Throughput: one result per cycle while `rsp_ready` stays high.
- No combinational path from `req_a`/`req_b` to any output. All response outputs are registered.
- Fairness: with all `NREQ` requesters continuously valid and `rsp_ready`=1, each is granted exactly once every `NREQ` cycles.

## Configuration
- Macro: `ADD8U_SHARE_APPROX_EN`.
- Defined: the shared core is approximate.
  - `sum[2:0]` = 3'b111.
  - `sum[3]` = `a[3]`.
  - `sum[8:4]` = `a[7:4]` + `b[7:4]`, 5 bits.
  - Bits `a[2:0]`, `b[2:0]` and `b[3]` are ignored.
- Undefined: the core is the exact 9-bit sum.
- Arbitration, handshake and timing are identical in both builds.

## Structure
- Package `add8u_share_pkg` holds:
  - `sum_t` (9-bit logic).
  - `opnd_t` (8-bit logic).
  - `MAX_NREQ`=8.
  - `CNT_W`=16.
  - Function `rr_pick(valid, ptr)` returning the one-hot grant.
- One sub-module, `add8u_share_core`: a combinational adder taking `opnd_t` a, b and returning `sum_t`. The `ADD8U_SHARE_APPROX_EN` switch lives inside it.
- The arbiter, output register and counter stay in the top module.

## Test plan
- Reset release with `req_valid`=4'b0000 -> `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `op_count`=0, `req_ready`=0.
- Requester 2 only, a=0x5A, b=0x33, `rsp_ready`=1 -> one cycle later `rsp_sum`=0x08D (exact) or 0x08F (`ADD8U_SHARE_APPROX_EN`), `rsp_id`=2, `op_count`=1 after the handshake.
- All four valid, a=0xFF, b=0xFF, `rsp_ready`=1 for 8 cycles -> `rsp_id` sequence 0,1,2,3,0,1,2,3, each `rsp_sum`=0x1FE (exact) or 0x1EF (approximate).
- FULL with `rsp_ready`=0 for 5 cycles while requester 1 is valid -> `req_ready`=0 and `rsp_sum`/`rsp_id` stable. `rsp_ready`=1 -> drain and grant to requester 1 in the same cycle, `rsp_valid` stays 1.
- `rst_n` driven low for 1 cycle while FULL and `op_count`=7 -> all outputs return to their reset values; `rr_ptr`=0, so requester 0 wins the next grant when all are valid.
- Preload 0xFFFE completions, then two more handshakes -> `op_count` reads 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/add8u_share_arb_pkg.sv
// Shared types, sizing constants and the round-robin pick helper for the
// add8u_share_arb block. Build macro ADD8U_SHARE_APPROX_EN selects the
// approximate adder core (see add8u_share_core).
package add8u_share_pkg;

  localparam int MAX_NREQ = 8;
  localparam int CNT_W    = 16;
  localparam int PTR_W    = $clog2(MAX_NREQ);

  typedef logic [8:0] sum_t;
  typedef logic [7:0] opnd_t;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  // One-hot grant of the first set bit at or above ptr, wrapping past the top.
  // Callers zero-extend a narrower request vector and keep ptr below their
  // requester count, so wrapping at MAX_NREQ-1 is equivalent to wrapping at
  // NREQ-1: the unused upper bits are never set.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] valid,
    input logic [PTR_W-1:0]    ptr
  );
    logic [MAX_NREQ-1:0] gnt;
    logic [PTR_W-1:0]    idx;
    gnt = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (gnt == '0 && valid[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/add8u_share_arb_if.sv
// Requester and response bundle for add8u_share_arb. The slave modport is the
// arbiter side; the master modport is the client/consumer side.
interface add8u_share_arb_if #(
  parameter int NREQ = 4
);
  import add8u_share_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  sum_t              rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic [CNT_W-1:0]  op_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, op_count
  );

endinterface

// File: rtl/add8u_share_arb_core.sv
// Shared 8-bit unsigned adder core, purely combinational.
// ADD8U_SHARE_APPROX_EN defined: approximate sum (low three bits forced high,
// bit 3 copied from a, upper nibbles added). Undefined: exact 9-bit sum.
module add8u_share_core
  import add8u_share_pkg::*;
(
  input  opnd_t a,
  input  opnd_t b,
  output sum_t  sum
);

`ifdef ADD8U_SHARE_APPROX_EN
  // The approximation deliberately ignores these operand bits.
  logic unused_lsbs;
  assign unused_lsbs = ^{a[2:0], b[3:0]};

  assign sum = {5'({1'b0, a[7:4]} + {1'b0, b[7:4]}), a[3], 3'b111};
`else
  assign sum = {1'b0, a} + {1'b0, b};
`endif

endmodule

// File: rtl/add8u_share_arb.sv
// Round-robin arbiter that time-multiplexes one add8u_share_core among NREQ
// requesters and returns each registered sum with the winner's ID on a single
// valid/ready response port. Build macro ADD8U_SHARE_APPROX_EN selects the
// approximate core; arbitration and timing are the same in both builds.
module add8u_share_arb
  import add8u_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input logic              clk,
  input logic              rst_n,
  add8u_share_arb_if.slave bus
);

  rsp_state_e       state_q, state_d;
  sum_t             sum_q, sum_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                can_issue;
  logic [MAX_NREQ-1:0] pick;
  logic [NREQ-1:0]     gnt;
  logic                gnt_any;
  logic [IDW-1:0]      gnt_idx;
  opnd_t               a_sel, b_sel;
  sum_t                core_sum;

  // Only the low NREQ bits of the pick can be set; the rest are folded here.
  logic unused_pick;
  assign unused_pick = ^pick;

  // Grant: round-robin pick from rr_ptr, only when the output slot can take data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    can_issue = (state_q == ST_EMPTY) || bus.rsp_ready;
    pick      = rr_pick(MAX_NREQ'(bus.req_valid), PTR_W'(ptr_q));
    gnt       = '0;
    if (rst_n && can_issue) gnt = pick[NREQ-1:0];
    gnt_any = |gnt;
    gnt_idx = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IDW'(i);
        a_sel   = bus.req_a[i*8 +: 8];
        b_sel   = bus.req_b[i*8 +: 8];
      end
    end
  end

  add8u_share_core u_core (
    .a   (a_sel),
    .b   (b_sel),
    .sum (core_sum)
  );

  // Next state: load on grant, drain on handshake, count every handshake.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (state_q == ST_FULL && bus.rsp_ready) cnt_d = cnt_q + 1'b1;
    if (gnt_any) begin
      state_d = ST_FULL;
      sum_d   = core_sum;
      id_d    = gnt_idx;
      ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (bus.rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_id    = id_q;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_add8u_share_arb.sv
// Self-checking bench for add8u_share_arb (NREQ=4): directed scenarios plus a
// randomized phase, all compared against a behavioural model of the block.
// Honours ADD8U_SHARE_APPROX_EN for the expected sums.
module tb_add8u_share_arb;

  localparam int NREQ = 4;

`ifdef ADD8U_SHARE_APPROX_EN
  localparam logic [8:0] EXP_T2 = 9'h08F;
  localparam logic [8:0] EXP_FF = 9'h1EF;
`else
  localparam logic [8:0] EXP_T2 = 9'h08D;
  localparam logic [8:0] EXP_FF = 9'h1FE;
`endif

  logic clk;
  logic rst_n;

  add8u_share_arb_if #(.NREQ(NREQ)) bus ();

  add8u_share_arb #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic [7:0]  a_arr [NREQ];
  logic [7:0]  b_arr [NREQ];
  bit          m_valid;
  int          m_sum;
  int          m_id;
  int          m_ptr;
  int          m_cnt;
  bit          quiet;

  function automatic int ref_add(input int a, input int b);
`ifdef ADD8U_SHARE_APPROX_EN
    return ((((a / 16) + (b / 16)) % 32) * 16) + (((a / 8) % 2) * 8) + 7;
`else
    return a + b;
`endif
  endfunction

  // Index granted this cycle by the model, or -1 for none.
  function automatic int model_grant(input logic [3:0] v, input logic rr, input logic rst_v);
    if (!rst_v || (m_valid && !rr)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check req_ready, then registered outputs after the edge.
  task automatic cycle(input logic [3:0] v, input logic rr, input logic rst_v);
    int g;
    logic [3:0] exp_rdy;
    @(negedge clk);
    rst_n         = rst_v;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*8 +: 8] = a_arr[i];
      bus.req_b[i*8 +: 8] = b_arr[i];
    end
    #1;
    g = model_grant(v, rr, rst_v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (!quiet) check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_v) begin
      m_valid = 0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_valid && rr) m_cnt = (m_cnt + 1) % 65536;
      if (g >= 0) begin
        m_valid = 1;
        m_sum   = ref_add(int'(a_arr[g]), int'(b_arr[g]));
        m_id    = g;
        m_ptr   = (g + 1) % NREQ;
      end else if (rr) begin
        m_valid = 0;
      end
    end
    #1;
    if (!quiet) begin
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      check("rsp_sum",   32'(bus.rsp_sum),   32'(m_sum));
      check("rsp_id",    32'(bus.rsp_id),    32'(m_id));
      check("op_count",  32'(bus.op_count),  32'(m_cnt));
    end
  endtask

  initial begin
    logic [8:0] held_sum;
    logic [1:0] held_id;
    int guard;

    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    m_valid = 0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0; quiet = 0;

    // Reset, then release with nothing valid.
    cycle(4'h0, 1'b0, 1'b0);
    cycle(4'h0, 1'b0, 1'b0);
    cycle(4'h0, 1'b0, 1'b1);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_sum",   32'(bus.rsp_sum),   32'd0);
    check("rst_cnt",   32'(bus.op_count),  32'd0);

    // Requester 2 alone.
    a_arr[2] = 8'h5A; b_arr[2] = 8'h33;
    cycle(4'b0100, 1'b1, 1'b1);
    check("t2_sum", 32'(bus.rsp_sum), 32'(EXP_T2));
    check("t2_id",  32'(bus.rsp_id),  32'd2);
    cycle(4'b0000, 1'b1, 1'b1);
    check("t2_cnt", 32'(bus.op_count), 32'd1);

    // Fairness from a fresh pointer: all valid, rsp_ready high.
    cycle(4'h0, 1'b1, 1'b0);
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = 8'hFF; b_arr[i] = 8'hFF; end
    for (int j = 0; j < 8; j++) begin
      cycle(4'hF, 1'b1, 1'b1);
      check("rr_id",  32'(bus.rsp_id),  32'(j % NREQ));
      check("rr_sum", 32'(bus.rsp_sum), 32'(EXP_FF));
    end

    // Backpressure while FULL, then drain and grant in the same cycle.
    a_arr[1] = 8'h12; b_arr[1] = 8'h34;
    held_sum = bus.rsp_sum;
    held_id  = bus.rsp_id;
    for (int j = 0; j < 5; j++) begin
      cycle(4'b0010, 1'b0, 1'b1);
      check("bp_sum", 32'(bus.rsp_sum), 32'(EXP_FF));
      check("bp_id",  32'(bus.rsp_id),  32'd3);
    end
    cycle(4'b0010, 1'b1, 1'b1);
    check("dg_valid", 32'(bus.rsp_valid), 32'd1);
    check("dg_id",    32'(bus.rsp_id),    32'd1);
    check("dg_sum",   32'(bus.rsp_sum),   32'(ref_add(32'h12, 32'h34)));

    // Mid-operation reset while FULL with op_count=7.
    cycle(4'h0, 1'b1, 1'b0);
    for (int j = 0; j < 8; j++) cycle(4'b0010, 1'b1, 1'b1);
    check("pre_cnt", 32'(bus.op_count), 32'd7);
    cycle(4'hF, 1'b0, 1'b0);
    check("mr_valid", 32'(bus.rsp_valid), 32'd0);
    check("mr_sum",   32'(bus.rsp_sum),   32'd0);
    check("mr_id",    32'(bus.rsp_id),    32'd0);
    check("mr_cnt",   32'(bus.op_count),  32'd0);
    cycle(4'hF, 1'b1, 1'b1);
    check("mr_first", 32'(bus.rsp_id), 32'd0);

    // Counter wrap: preload 0xFFFE completions, then two more handshakes.
    cycle(4'h0, 1'b1, 1'b0);
    quiet = 1;
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      cycle(4'b0001, 1'b1, 1'b1);
      guard++;
    end
    quiet = 0;
    check("pre_wrap", 32'(bus.op_count), 32'hFFFE);
    cycle(4'b0000, 1'b1, 1'b1);
    check("cnt_ffff", 32'(bus.op_count), 32'hFFFF);
    cycle(4'b0001, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1);
    check("cnt_wrap", 32'(bus.op_count), 32'h0000);

    // Randomized traffic, occasional reset.
    for (int j = 0; j < 400; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i] = 8'($urandom);
        b_arr[i] = 8'($urandom);
      end
      cycle(4'($urandom), 1'($urandom), ($urandom_range(0, 49) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
